// File: rtl/issue_window.sv
// issue_window: in-order issue buffer in front of exec, with flush and a stall counter.
// Optional same-cycle bypass when empty is enabled by defining ISSUE_WINDOW_BYPASS_EN.
`ifndef LEN_EXEC_INFO
`define LEN_EXEC_INFO 32
`endif

module issue_window #(
    parameter int DEPTH  = 4,
    parameter int W_INFO = `LEN_EXEC_INFO
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [W_INFO-1:0]      in_exec_info,
    output logic                   in_ready,
    output logic                   order,
    output logic [W_INFO-1:0]      exec_info,
    input  logic                   accepted,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            stall_cycles
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [W_INFO-1:0] entry [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              stored;
    logic              bypass;
    logic              push;
    logic              pop;

    assign stored   = (count != '0);
    assign in_ready = (count != FULL) & ~flush;

`ifdef ISSUE_WINDOW_BYPASS_EN
    assign bypass = ~stored & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign order     = stored | bypass;
    assign exec_info = bypass ? in_exec_info : entry[head];
    assign pop       = stored & accepted;
    // A bypassed entry taken by exec in the same cycle is never stored.
    assign push      = in_valid & in_ready & ~(bypass & accepted);

    // Entry storage: written at the tail on push, untouched by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (push) begin
            entry[tail] <= in_exec_info;
        end
    end

    // Head/tail/count bookkeeping; flush clears everything and wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            unique case (1'b1)
                push & ~pop: count <= count + 1'b1;
                pop & ~push: count <= count - 1'b1;
                default:     count <= count;
            endcase
        end
    end

    // Saturating count of offered-but-not-taken cycles; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (order & ~accepted & (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_issue_window.sv
// tb_issue_window: directed + random stimulus against a queue-based model.
// Covers fill/full, streaming, flush, stall saturation, async reset, bypass.
module tb_issue_window;

    localparam int DEPTH = 4;
    localparam int W     = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic [W-1:0]           in_exec_info;
    logic                   in_ready;
    logic                   order;
    logic [W-1:0]           exec_info;
    logic                   accepted;
    logic                   flush;
    logic [$clog2(DEPTH):0] count;
    logic [15:0]            stall_cycles;

    issue_window #(.DEPTH(DEPTH), .W_INFO(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_exec_info (in_exec_info),
        .in_ready     (in_ready),
        .order        (order),
        .exec_info    (exec_info),
        .accepted     (accepted),
        .flush        (flush),
        .count        (count),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    logic [W-1:0] q[$];
    int           stall_m;
    int           ntot;
    int           npass;
    int           nfail;
    bit           chk_on;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check outputs mid-cycle, then advance the model and the clock.
    task automatic cycle();
        int n;
        bit byp;
        bit exp_order;
        @(negedge clk);
        n   = q.size();
        byp = 1'b0;
`ifdef ISSUE_WINDOW_BYPASS_EN
        byp = (n == 0) && in_valid && !flush;
`endif
        exp_order = (n != 0) || byp;
        if (chk_on) begin
            chk("order", 64'(order), 64'(exp_order));
            chk("count", 64'(count), 64'(n));
            chk("in_ready", 64'(in_ready),
                64'((n != DEPTH) && !flush));
            chk("stall", 64'(stall_cycles), 64'(stall_m));
            if (n != 0)
                chk("exec_info", 64'(exec_info), 64'(q[0]));
            else if (byp)
                chk("byp_info", 64'(exec_info), 64'(in_exec_info));
        end
        if (exp_order && !accepted)
            stall_m = (stall_m == 65535) ? 65535 : stall_m + 1;
        if (flush) begin
            q.delete();
        end else if (!(byp && accepted)) begin
            if (n != 0 && accepted) void'(q.pop_front());
            if (in_valid && n < DEPTH) q.push_back(in_exec_info);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_order"}, 64'(order), 64'(0));
        chk({tag, "_count"}, 64'(count), 64'(0));
        chk({tag, "_stall"}, 64'(stall_cycles), 64'(0));
        chk({tag, "_info"}, 64'(exec_info), 64'(0));
        chk({tag, "_ready"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        ntot = 0; npass = 0; nfail = 0;
        chk_on = 1'b1;
        stall_m = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_exec_info = '0;
        accepted = 1'b0;
        flush = 1'b0;
        #1;
        reset_checks("rst_during");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        reset_checks("rst_after");

        // Push A, B, C with exec stalled.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_exec_info = $urandom;
            cycle();
        end
        // Fill to DEPTH, then hold in_valid while full.
        in_exec_info = $urandom;
        cycle();
        in_exec_info = $urandom;
        cycle();
        cycle();
        accepted = 1'b1;
        cycle();
        in_valid = 1'b0;
        accepted = 1'b0;
        cycle();

        // Drain to one entry, then stream push+accept for 12 cycles.
        accepted = 1'b1;
        while (q.size() > 1) cycle();
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_exec_info = $urandom;
            cycle();
        end

        // Build 3 entries, flush with accept and push together.
        accepted = 1'b0;
        while (q.size() < 3) begin
            in_exec_info = $urandom;
            cycle();
        end
        flush = 1'b1;
        accepted = 1'b1;
        in_exec_info = $urandom;
        cycle();
        flush = 1'b0;
        accepted = 1'b0;
        in_exec_info = $urandom;
        cycle();
        in_valid = 1'b0;
        cycle();
        accepted = 1'b1;
        cycle();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            accepted = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 15) == 0);
            in_exec_info = $urandom;
            cycle();
        end

        // Empty window, push X with accept in the same cycle.
        in_valid = 1'b0;
        flush = 1'b1;
        accepted = 1'b0;
        cycle();
        flush = 1'b0;
        in_valid = 1'b1;
        accepted = 1'b1;
        in_exec_info = $urandom;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        // Long stall to saturate the counter.
        in_valid = 1'b1;
        accepted = 1'b0;
        in_exec_info = $urandom;
        cycle();
        in_valid = 1'b0;
        chk_on = 1'b0;
        for (int i = 0; i < 70000; i++) cycle();
        chk_on = 1'b1;
        cycle();
        chk("stall_sat", 64'(stall_cycles), 64'(16'hFFFF));
        cycle();

        // Asynchronous reset mid-cycle.
        #3;
        rst = 1'b1;
        #1;
        reset_checks("rst_async");
        q.delete();
        stall_m = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_exec_info = $urandom;
        cycle();
        in_valid = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
